// File: rtl/key_cond_pkg.sv
// Shared types, default 50 MHz timing and counter sizing for the key conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } key_state_t;

  localparam int DEF_DEBOUNCE_CYCLES      = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 15_000_000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 3_000_000;

  // Bits needed for a down/up counter spanning 0 .. num_states-1.
  function automatic int cnt_width(input int num_states);
    return (num_states > 2) ? $clog2(num_states) : 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, counter debouncer and press/auto-repeat FSM.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter bit REPEAT_ENABLE        = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic key_raw_n,
  output logic level_n,
  output logic key_event,
  output logic key_held
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW = cnt_width(RMAX);
  localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  key_state_t    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          event_q, event_d;
  logic          held_q, held_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      dcnt_q   <= '0;
      state_q  <= IDLE;
      rcnt_q   <= '0;
      event_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      sync1_q  <= key_raw_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      event_q  <= event_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    if (sync2_q == stable_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      stable_d = sync2_q;
      dcnt_d   = '0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  // The FSM looks at stable_d so the press event lands on the same edge as the level change.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    event_d = 1'b0;
    held_d  = (state_q == REPEAT);
    case (state_q)
      IDLE: begin
        if (stable_q && !stable_d) begin
          state_d = DELAY;
          rcnt_d  = DELAY_LOAD;
          event_d = 1'b1;
        end
      end
      DELAY: begin
        if (stable_d) begin
          state_d = IDLE;
        end else if (rcnt_q == '0) begin
          if (REPEAT_ENABLE) begin
            state_d = REPEAT;
            rcnt_d  = PERIOD_LOAD;
            event_d = 1'b1;
          end
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      REPEAT: begin
        if (stable_d) begin
          state_d = IDLE;
        end else if (rcnt_q == '0) begin
          rcnt_d  = PERIOD_LOAD;
          event_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_n   = stable_q;
  assign key_event = event_q;
  assign key_held  = held_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces the board push-buttons for the keys PIO and adds press/auto-repeat events.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int                    NUM_KEYS             = 2,
  parameter int                    DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int                    REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int                    REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter logic [NUM_KEYS-1:0]   REPEAT_EN            = {NUM_KEYS{1'b1}}
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] keys_level_n,
  output logic [NUM_KEYS-1:0] key_event,
  output logic [NUM_KEYS-1:0] key_held
);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
      .REPEAT_ENABLE       (REPEAT_EN[gi])
    ) u_channel (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .key_raw_n    (key_raw_n[gi]),
      .level_n      (keys_level_n[gi]),
      .key_event    (key_event[gi]),
      .key_held     (key_held[gi])
    );
  end

endmodule
